// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: receiver state type, default 640x480 timing and derived line/frame totals.
package vga_rx_pkg;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam int DEF_RES_H  = 640;
  localparam int DEF_FP_H   = 16;
  localparam int DEF_SYNC_H = 96;
  localparam int DEF_BP_H   = 48;
  localparam int DEF_RES_V  = 480;
  localparam int DEF_FP_V   = 10;
  localparam int DEF_SYNC_V = 2;
  localparam int DEF_BP_V   = 33;
  function automatic int calc_h_total(int res, int fp, int sync, int bp);
    return res + fp + sync + bp;
  endfunction
  function automatic int calc_v_total(int res, int fp, int sync, int bp);
    return res + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: CRC-16/CCITT over 12-bit pixels (zero-extended, MSB first), latched and re-seeded per frame.
module vga_crc16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [11:0] data,
  input  logic        frame,
  output logic [15:0] crc
);
  logic [15:0] acc;
  function automatic logic [15:0] step(logic [15:0] c, logic [15:0] d);
    for (int i = 15; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      acc <= 16'hFFFF;
      crc <= '0;
    end else if (frame) begin
      crc <= acc;
      acc <= 16'hFFFF;
    end else if (valid) begin
      acc <= step(acc, {4'h0, data});
    end
endmodule

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers a level and flags its leading/trailing edges on the registered copy.
module vga_edge_det (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic p;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      q <= 1'b0;
      p <= 1'b0;
    end else begin
      q <= d;
      p <= q;
    end
  assign rise = q & ~p;
  assign fall = ~q & p;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA receive front end - sync normalisation, pixel coordinates, timing lock and error.
// Optional VGA_SYNC_RX_CRC_EN adds a per-frame CRC-16 of the pixel stream on frame_crc.
module vga_sync_rx
  import vga_rx_pkg::*;
#(
  parameter int RES_H  = DEF_RES_H,
  parameter int FP_H   = DEF_FP_H,
  parameter int SYNC_H = DEF_SYNC_H,
  parameter int BP_H   = DEF_BP_H,
  parameter bit NEG_H  = 1'b1,
  parameter int RES_V  = DEF_RES_V,
  parameter int FP_V   = DEF_FP_V,
  parameter int SYNC_V = DEF_SYNC_V,
  parameter int BP_V   = DEF_BP_V,
  parameter bit NEG_V  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic        locked,
  output logic        err
`ifdef VGA_SYNC_RX_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);
  localparam logic [11:0] MAX    = 12'hFFF;
  localparam logic [11:0] HT     = 12'(calc_h_total(RES_H, FP_H, SYNC_H, BP_H));
  localparam logic [11:0] VT     = 12'(calc_v_total(RES_V, FP_V, SYNC_V, BP_V));
  localparam logic [11:0] LAST_X = 12'(RES_H - 1);
  localparam logic [11:0] LINES  = 12'(RES_V);
  localparam logic [11:0] SW     = 12'(SYNC_H);
  logic hs_q, hs_rise, hs_fall, vs_q, vs_rise, vs_fall_unused, de_q, de_rise, de_fall;
  logic [11:0] rgb_q, hcnt, hw_cnt, lcnt, lcnt_n, al_cnt;
  logic line_bad, hsw_bad, line_err, hsw_err, frame_bad, drop;
  state_t state, nxt;
  vga_edge_det u_hs (.clock, .reset_n, .d(hs ^ NEG_H), .q(hs_q), .rise(hs_rise), .fall(hs_fall));
  vga_edge_det u_vs (.clock, .reset_n, .d(vs ^ NEG_V), .q(vs_q), .rise(vs_rise), .fall(vs_fall_unused));
  vga_edge_det u_de (.clock, .reset_n, .d(de), .q(de_q), .rise(de_rise), .fall(de_fall));
  // a coincident hsync edge is counted into the frame it closes
  assign lcnt_n    = (hs_rise && lcnt != MAX) ? lcnt + 12'd1 : lcnt;
  assign line_err  = (de_fall && pix_x != LAST_X) || (de_q && (hs_q || vs_q));
  assign hsw_err   = hs_fall && hw_cnt != SW;
  assign frame_bad = line_bad || line_err || hsw_bad || hsw_err ||
                     al_cnt != LINES || h_total != HT || lcnt_n != VT;
  assign locked    = state == LOCKED;
  always_comb begin
    drop = state == LOCKED && (line_err || hsw_err || (vs_rise && frame_bad));
    nxt  = drop ? SEARCH : !vs_rise ? state : state == SEARCH ? MEASURE : frame_bad ? MEASURE : LOCKED;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= SEARCH;
    else state <= nxt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rgb_q       <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      hcnt        <= '0;
      h_total     <= '0;
      hw_cnt      <= '0;
      lcnt        <= '0;
      v_total     <= '0;
      al_cnt      <= '0;
      line_bad    <= 1'b0;
      hsw_bad     <= 1'b0;
      err         <= 1'b0;
    end else begin
      rgb_q       <= {R, G, B};
      pix_valid   <= de_q;
      pix_rgb     <= rgb_q;
      pix_x       <= de_rise ? '0 : (de_q && pix_x != MAX) ? pix_x + 12'd1 : pix_x;
      pix_y       <= vs_rise ? '0 : de_fall ? pix_y + 12'd1 : pix_y;
      frame_start <= de_rise && pix_y == '0;
      hcnt        <= hs_rise ? '0 : hcnt == MAX ? hcnt : hcnt + 12'd1;
      h_total     <= !hs_rise ? h_total : hcnt == MAX ? MAX : hcnt + 12'd1;
      hw_cnt      <= hs_rise ? 12'd1 : (hs_q && hw_cnt != MAX) ? hw_cnt + 12'd1 : hw_cnt;
      lcnt        <= vs_rise ? '0 : lcnt_n;
      v_total     <= vs_rise ? lcnt_n : v_total;
      al_cnt      <= vs_rise ? '0 : (de_fall && al_cnt != MAX) ? al_cnt + 12'd1 : al_cnt;
      line_bad    <= !vs_rise && (line_bad || line_err);
      hsw_bad     <= !vs_rise && (hsw_bad || hsw_err);
      err         <= drop ? 1'b1 : (state == SEARCH && vs_rise) ? 1'b0 : err;
    end
`ifdef VGA_SYNC_RX_CRC_EN
  vga_crc16 u_crc (.clock, .reset_n, .valid(pix_valid), .data(pix_rgb), .frame(vs_rise), .crc(frame_crc));
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a reduced 8x4 mode (16 clocks x 8 lines).
// Define VGA_SYNC_RX_CRC_EN to also check frame_crc against a reference CRC.
module tb_vga_sync_rx;
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] rgb;
    logic        fs;
  } pix_t;
  logic clock = 1'b0, reset_n;
  logic [3:0] R, G, B;
  logic hs, vs, de;
  logic pix_valid, frame_start, locked, err;
  logic [11:0] pix_x, pix_y, pix_rgb, h_total, v_total;
`ifdef VGA_SYNC_RX_CRC_EN
  logic [15:0] frame_crc;
`endif
  pix_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, fall_cyc = 0, drop_cyc = 0, frame_no = 0;
  logic sb_en = 1'b0, mon_en = 1'b0, prev_locked = 1'b0;

  vga_sync_rx #(
    .RES_H(8), .FP_H(2), .SYNC_H(3), .BP_H(3), .NEG_H(1'b1),
    .RES_V(4), .FP_V(1), .SYNC_V(1), .BP_V(2), .NEG_V(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .R(R), .G(G), .B(B), .hs(hs), .vs(vs), .de(de),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
    .locked(locked), .err(err)
`ifdef VGA_SYNC_RX_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && pix_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel: unexpected output x=%0d y=%0d rgb=%0h", pix_x, pix_y, pix_rgb);
      end else begin
        chk("pixel {x,y,rgb,fs}", 64'({pix_x, pix_y, pix_rgb, frame_start}), 64'(exp_q.pop_front()));
      end
    end
    if (prev_locked && !locked) drop_cyc <= cyc;
    prev_locked <= locked;
  end

  // sync at the start of each line/frame; de window x in 6..13, y in 3..6
  task automatic gen_frame(input int bad_line, input bit inv, input bit crgb);
    int ax, ay;
    logic act;
    logic [11:0] rgb;
    frame_no++;
    for (int vc = 0; vc < 8; vc++)
      for (int hc = 0; hc < 16; hc++) begin
        @(negedge clock);
        ax  = hc - 6;
        ay  = vc - 3;
        act = ay >= 0 && ay < 4 && ax >= 0 && ax < (ay == bad_line ? 7 : 8);
        rgb = crgb ? 12'hFFF : {ax[3:0], ay[3:0], frame_no[3:0]};
        hs  = inv ? (hc < 3) : !(hc < 3);
        vs  = !(vc < 1);
        de  = act;
        {R, G, B} = rgb;
        if (ay == bad_line && ax == 7) fall_cyc = cyc;
        if (act && sb_en) exp_q.push_back('{x: 12'(ax), y: 12'(ay), rgb: rgb, fs: ax == 0 && ay == 0});
      end
  endtask

`ifdef VGA_SYNC_RX_CRC_EN
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c = 16'hFFFF;
    for (int p = 0; p < n; p++) begin
      c ^= 16'h0FFF;
      for (int b = 0; b < 16; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  initial begin
    reset_n = 1'b0;
    {R, G, B} = '0;
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      hs = !(i < 3);
      de = i >= 6;
      {R, G, B} = 12'(i * 37 + 5);
    end
    chk("valid before reset", 64'(pix_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("async reset outputs", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start,
                                       h_total, v_total, locked, err}), 64'd0);
    @(negedge clock);
    hs = 1'b1;
    de = 1'b0;
    repeat (2) @(negedge clock);
    chk("outputs held in reset", 64'({pix_valid, h_total, locked, err}), 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("search after release", 64'(locked), 64'd0);
    sb_en = 1'b1;
    mon_en = 1'b1;
    gen_frame(-1, 1'b0, 1'b0);
    chk("measure after 1st vsync", 64'(locked), 64'd0);
    gen_frame(-1, 1'b0, 1'b0);
    chk("h_total", 64'(h_total), 64'd16);
    chk("v_total", 64'(v_total), 64'd8);
    chk("locked after 2nd vsync", 64'(locked), 64'd1);
    chk("err clean", 64'(err), 64'd0);
    gen_frame(-1, 1'b0, 1'b0);
    chk("still locked", 64'({locked, err}), 64'b10);
    chk("v_total frame 3", 64'(v_total), 64'd8);
    gen_frame(1, 1'b0, 1'b0);
    chk("locked after short line", 64'(locked), 64'd0);
    chk("err after short line", 64'(err), 64'd1);
    chk("drop cycle after de fall", 64'(drop_cyc), 64'(fall_cyc + 2));
    gen_frame(-1, 1'b0, 1'b0);
    chk("err cleared at vsync in search", 64'({locked, err}), 64'b00);
    gen_frame(-1, 1'b0, 1'b0);
    chk("relocked", 64'(locked), 64'd1);
    for (int f = 0; f < 3; f++) begin
      gen_frame(-1, 1'b1, 1'b0);
      chk("inverted hs never locks", 64'(locked), 64'd0);
    end
    chk("h_total inverted hs", 64'(h_total), 64'd16);
`ifdef VGA_SYNC_RX_CRC_EN
    for (int f = 0; f < 3; f++) begin
      gen_frame(-1, 1'b0, 1'b1);
      if (f > 0) chk("frame_crc", 64'(frame_crc), 64'(crc_model(32)));
    end
`endif
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    repeat (4) @(negedge clock);
    chk("pixels drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
